branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_pkg.sv | 29 ++
 rtl/branch_cond.sv | 54 +++++
 rtl/branch_resolve.sv | 133 +++++++++++++
 tb/tb_branch_resolve.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared opcodes, REGIMM rt codes, FSM encoding and target helper for branch resolution
//
// Contents:
//   state_t        : resolver FSM states (IDLE, HOLD, REDIR)
//   OP_*           : primary opcodes of the branch instructions handled in ID
//   RT_*           : rt-field sub-opcodes under OP_REGIMM
//   branch_target  : pc + 4 + (sign-extended imm16 << 2), modulo 2^32

package branch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;

    function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] imm);
        return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - combinational branch decode and condition evaluation
//
// Ports:
//   opcode    : instr[31:26]
//   rt        : instr[20:16], selects bltz/bgez under REGIMM
//   a, b      : comparison operands (already forwarded)
//   is_branch : opcode/rt names a supported branch
//   taken     : branch condition holds (only meaningful with is_branch)

module branch_cond
    import branch_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [4:0]  rt,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        is_branch,
    output logic        taken
);

    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        case (opcode)
            OP_BEQ: begin
                is_branch = 1'b1;
                taken     = (a == b);
            end
            OP_BNE: begin
                is_branch = 1'b1;
                taken     = (a != b);
            end
            OP_BGTZ: begin
                is_branch = 1'b1;
                taken     = !a[31] && (a != 32'd0);
            end
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ: begin
                        is_branch = 1'b1;
                        taken     = a[31];
                    end
                    RT_BGEZ: begin
                        is_branch = 1'b1;
                        taken     = !a[31];
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - ID-stage branch resolver with stall hold, one-cycle redirect and statistics
//
// Ports:
//   clock, resetn                : clock, synchronous active-low reset
//   id_valid, id_instr, id_pc    : instruction currently in ID
//   rs_data, rt_data             : register-file operands
//   ex_fwd_data                  : forwarded ID/EX result
//   cmp_forwarda, cmp_forwardb   : pick ex_fwd_data for operand A / B
//   stall                        : hazard unit holds the branch
//   clr_stats                    : zero the statistics counters
//   redirect, redirect_pc        : one-cycle fetch redirect and its target
//   flush_ifid                   : squash IF/ID, same as redirect
//   busy                         : resolver is holding a stalled branch
//   taken_count, stall_count     : saturating REDIR / HOLD cycle counters

module branch_resolve
    import branch_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic [31:0]      ex_fwd_data,
    input  logic             cmp_forwarda,
    input  logic             cmp_forwardb,
    input  logic             stall,
    input  logic             clr_stats,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush_ifid,
    output logic             busy,
    output logic [CNT_W-1:0] taken_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t      state, next_state;
    logic [31:0] lat_instr, lat_pc, tgt_q;
    logic [31:0] eval_instr, eval_pc, op_a, op_b;
    logic        is_branch, cond_taken;
    logic        in_idle, in_hold, start_hold, eval_now, take;
    logic        unused_rs;

    assign in_idle = (state == ST_IDLE);
    assign in_hold = (state == ST_HOLD);

    // While holding, the latched copy is evaluated; whatever sits in ID is ignored.
    assign eval_instr = in_hold ? lat_instr : id_instr;
    assign eval_pc    = in_hold ? lat_pc    : id_pc;
    assign unused_rs  = ^eval_instr[25:21];

    // Operands are always taken live, so forwarding that resolves during the hold is seen.
    assign op_a = cmp_forwarda ? ex_fwd_data : rs_data;
    assign op_b = cmp_forwardb ? ex_fwd_data : rt_data;

    branch_cond u_cond (
        .opcode    (eval_instr[31:26]),
        .rt        (eval_instr[20:16]),
        .a         (op_a),
        .b         (op_b),
        .is_branch (is_branch),
        .taken     (cond_taken)
    );

    // A latched instruction is always a branch, so HOLD only waits on stall.
    assign start_hold = in_idle && id_valid && is_branch && stall;
    assign eval_now   = (in_idle && id_valid && is_branch && !stall) || (in_hold && !stall);
    assign take       = eval_now && cond_taken;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  next_state = start_hold ? ST_HOLD : (take ? ST_REDIR : ST_IDLE);
            ST_HOLD:  next_state = stall ? ST_HOLD : (take ? ST_REDIR : ST_IDLE);
            ST_REDIR: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        redirect   = (state == ST_REDIR);
        flush_ifid = (state == ST_REDIR);
        busy       = (state == ST_HOLD);
    end

    assign redirect_pc = tgt_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            lat_instr <= 32'd0;
            lat_pc    <= 32'd0;
            tgt_q     <= 32'd0;
        end else begin
            if (start_hold) begin
                lat_instr <= id_instr;
                lat_pc    <= id_pc;
            end
            if (take) begin
                tgt_q <= branch_target(eval_pc, eval_instr[15:0]);
            end
        end
    end

    // clr_stats wins over a same-cycle increment.
    always_ff @(posedge clock) begin
        if (!resetn || clr_stats) begin
            taken_count <= '0;
            stall_count <= '0;
        end else begin
            if ((state == ST_REDIR) && (taken_count != CNT_MAX)) begin
                taken_count <= taken_count + 1'b1;
            end
            if (in_hold && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - scoreboard bench for branch_resolve

module tb_branch_resolve;
    import branch_pkg::*;

    logic        clock = 1'b0;
    logic        resetn;
    logic        id_valid;
    logic [31:0] id_instr, id_pc, rs_data, rt_data, ex_fwd_data;
    logic        cmp_forwarda, cmp_forwardb, stall, clr_stats;

    logic        redirect, flush_ifid, busy;
    logic [31:0] redirect_pc;
    logic [15:0] taken_count, stall_count;

    logic        s_redirect, s_flush, s_busy;
    logic [31:0] s_redirect_pc;
    logic [1:0]  s_taken, s_stall;

    always #5 clock = ~clock;

    branch_resolve dut (
        .clock(clock), .resetn(resetn), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .rs_data(rs_data), .rt_data(rt_data), .ex_fwd_data(ex_fwd_data),
        .cmp_forwarda(cmp_forwarda), .cmp_forwardb(cmp_forwardb), .stall(stall), .clr_stats(clr_stats),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush_ifid(flush_ifid), .busy(busy),
        .taken_count(taken_count), .stall_count(stall_count)
    );

    branch_resolve #(.CNT_W(2)) dut_sat (
        .clock(clock), .resetn(resetn), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .rs_data(rs_data), .rt_data(rt_data), .ex_fwd_data(ex_fwd_data),
        .cmp_forwarda(cmp_forwarda), .cmp_forwardb(cmp_forwardb), .stall(stall), .clr_stats(clr_stats),
        .redirect(s_redirect), .redirect_pc(s_redirect_pc), .flush_ifid(s_flush), .busy(s_busy),
        .taken_count(s_taken), .stall_count(s_stall)
    );

    typedef struct {
        logic [31:0] tgt;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every redirect pulse must match the oldest expected target at the expected cycle.
    always @(negedge clock) begin
        if (sb.size() > 0 && sb[0].at < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_redirect: got no pulse expected target %h", sb[0].tgt);
            void'(sb.pop_front());
        end
        if (redirect === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_redirect: got target %h expected no pulse", redirect_pc);
            end else begin
                mon_e = sb.pop_front();
                chk("redirect_cycle", cyc, mon_e.at);
                chk("redirect_pc", redirect_pc, mon_e.tgt);
                chk("flush_ifid", {31'd0, flush_ifid}, 32'd1);
                chk("sat_redirect_pc", s_redirect_pc, mon_e.tgt);
            end
        end
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
        return {op, 5'd3, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_redirect(input logic [31:0] tgt);
        exp_t e;
        e.tgt = tgt;
        e.at  = cyc + 1;
        sb.push_back(e);
    endtask

    // Present one unstalled instruction for a single cycle, then one idle cycle.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input bit exp_taken, input logic [31:0] tgt);
        id_valid = 1'b1;
        id_instr = instr;
        id_pc    = pc;
        rs_data  = a;
        rt_data  = b;
        stall    = 1'b0;
        if (exp_taken) expect_redirect(tgt);
        tick();
        id_valid = 1'b0;
        tick();
    endtask

    initial begin
        resetn = 1'b0; id_valid = 1'b0; id_instr = 32'd0; id_pc = 32'd0;
        rs_data = 32'd0; rt_data = 32'd0; ex_fwd_data = 32'd0;
        cmp_forwarda = 1'b0; cmp_forwardb = 1'b0; stall = 1'b0; clr_stats = 1'b0;
        tick();
        tick();
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_flush", {31'd0, flush_ifid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_taken", {16'd0, taken_count}, 32'd0);
        chk("rst_stall", {16'd0, stall_count}, 32'd0);
        chk("rst_sat_busy", {31'd0, s_busy | s_redirect | s_flush}, 32'd0);
        resetn = 1'b1;
        tick();

        // beq taken; a taken branch shown during REDIR is flushed, not evaluated
        id_valid = 1'b1; id_instr = mk(OP_BEQ, 5'd0, 16'h0004); id_pc = 32'h100;
        rs_data = 32'd5; rt_data = 32'd5;
        expect_redirect(32'h114);
        tick();
        id_instr = mk(OP_BEQ, 5'd0, 16'h0008); id_pc = 32'h200;
        tick();
        id_valid = 1'b0;
        chk("taken_after_beq", {16'd0, taken_count}, 32'd1);
        tick();
        chk("taken_redir_ignored", {16'd0, taken_count}, 32'd1);

        // bne equal: no pulse, nothing counted
        issue(mk(OP_BNE, 5'd0, 16'h0010), 32'h180, 32'd7, 32'd7, 1'b0, 32'd0);
        chk("bne_busy", {31'd0, busy}, 32'd0);
        chk("bne_taken", {16'd0, taken_count}, 32'd1);
        chk("bne_stall", {16'd0, stall_count}, 32'd0);

        issue(mk(OP_BNE, 5'd0, 16'hFFFF), 32'h40, 32'd1, 32'd2, 1'b1, 32'h40);
        issue(mk(OP_REGIMM, RT_BLTZ, 16'h0010), 32'h1000, 32'h80000000, 32'd0, 1'b1, 32'h1044);
        issue(mk(OP_REGIMM, RT_BLTZ, 16'h0010), 32'h1000, 32'd0, 32'd0, 1'b0, 32'd0);
        issue(mk(OP_REGIMM, RT_BGEZ, 16'h0001), 32'h2000, 32'd0, 32'd0, 1'b1, 32'h2008);
        issue(mk(OP_REGIMM, RT_BGEZ, 16'h0001), 32'h2000, 32'hFFFFFFFF, 32'd0, 1'b0, 32'd0);
        issue(mk(OP_BGTZ, 5'd0, 16'h0004), 32'h3000, 32'd0, 32'd0, 1'b0, 32'd0);
        issue(mk(OP_BGTZ, 5'd0, 16'h0004), 32'h3000, 32'hFFFFFFFF, 32'd0, 1'b0, 32'd0);
        issue(mk(OP_BGTZ, 5'd0, 16'hFFFE), 32'h20, 32'd5, 32'd0, 1'b1, 32'h1C);
        issue(mk(6'b000110, 5'd0, 16'h0004), 32'h3000, 32'd0, 32'd0, 1'b0, 32'd0);

        // forwarding on operand B makes beq taken; on operand A makes it not taken
        cmp_forwardb = 1'b1; ex_fwd_data = 32'd3;
        issue(mk(OP_BEQ, 5'd0, 16'h0000), 32'h500, 32'd3, 32'd9, 1'b1, 32'h504);
        cmp_forwardb = 1'b0; cmp_forwarda = 1'b1; ex_fwd_data = 32'd4;
        issue(mk(OP_BEQ, 5'd0, 16'h0000), 32'h500, 32'd3, 32'd3, 1'b0, 32'd0);
        cmp_forwarda = 1'b0;

        // target wraps modulo 2^32; unsupported REGIMM rt is not a branch
        issue(mk(OP_BEQ, 5'd0, 16'h8000), 32'h10, 32'd1, 32'd1, 1'b1, 32'hFFFE0014);
        issue(mk(OP_REGIMM, 5'b00010, 16'h0004), 32'h10, 32'h80000000, 32'd0, 1'b0, 32'd0);
        chk("taken_total", {16'd0, taken_count}, 32'd7);

        // bgtz held for 3 stall cycles, resolved via forwarding on release
        id_valid = 1'b1; id_instr = mk(OP_BGTZ, 5'd0, 16'h0002); id_pc = 32'h300;
        rs_data = 32'd0; stall = 1'b1;
        tick();
        chk("hold_busy1", {31'd0, busy}, 32'd1);
        id_instr = mk(OP_BEQ, 5'd0, 16'h0040); id_pc = 32'h900;
        tick();
        chk("hold_busy2", {31'd0, busy}, 32'd1);
        tick();
        chk("hold_busy3", {31'd0, busy}, 32'd1);
        stall = 1'b0; cmp_forwarda = 1'b1; ex_fwd_data = 32'd1;
        expect_redirect(32'h30C);
        tick();
        id_valid = 1'b0; cmp_forwarda = 1'b0;
        chk("hold_busy_redir", {31'd0, busy}, 32'd0);
        chk("hold_stall_count", {16'd0, stall_count}, 32'd3);
        tick();
        chk("hold_taken", {16'd0, taken_count}, 32'd8);
        chk("sat_taken", {30'd0, s_taken}, 32'd3);
        chk("sat_stall3", {30'd0, s_stall}, 32'd3);

        // reset while holding a taken-able branch: nothing comes out afterwards
        id_valid = 1'b1; id_instr = mk(OP_BGTZ, 5'd0, 16'h0002); id_pc = 32'h700;
        rs_data = 32'd5; stall = 1'b1;
        tick();
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        id_valid = 1'b0; stall = 1'b0; resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("rst_hold_busy", {31'd0, busy}, 32'd0);
        chk("rst_hold_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_hold_pc", redirect_pc, 32'd0);
        chk("rst_hold_taken", {16'd0, taken_count}, 32'd0);
        chk("rst_hold_stall", {16'd0, stall_count}, 32'd0);
        tick();
        tick();
        tick();
        chk("post_reset_busy", {31'd0, busy}, 32'd0);

        // stall counter saturation at CNT_W=2, then clr_stats concurrent with REDIR
        id_valid = 1'b1; id_instr = mk(OP_BEQ, 5'd0, 16'h0001); id_pc = 32'h600;
        rs_data = 32'd0; rt_data = 32'd0; stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        stall = 1'b0;
        expect_redirect(32'h608);
        tick();
        id_valid = 1'b0;
        chk("stall_count5", {16'd0, stall_count}, 32'd5);
        chk("sat_stall_max", {30'd0, s_stall}, 32'd3);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr_taken", {16'd0, taken_count}, 32'd0);
        chk("clr_stall", {16'd0, stall_count}, 32'd0);
        chk("clr_sat_taken", {30'd0, s_taken}, 32'd0);

        for (int i = 0; i < 4; i++)
            issue(mk(OP_BEQ, 5'd0, 16'h0002), 32'h800, 32'd1, 32'd1, 1'b1, 32'h80C);
        chk("taken4", {16'd0, taken_count}, 32'd4);
        chk("sat_taken_max", {30'd0, s_taken}, 32'd3);

        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
